// File: rtl/alu_exec_iter.sv
// rtl/alu_exec_iter.sv - ALU execute stage with bit-serial shifts and valid/ready handshakes (optional SRA: ALU_EXEC_SRA_EN)
module alu_exec_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_PASS = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_EXEC_SRA_EN
    localparam logic [3:0] OP_SRA  = 4'b1011;
`endif

    localparam logic [1:0] SH_LEFT  = 2'd0;
    localparam logic [1:0] SH_RIGHT = 2'd1;
`ifdef ALU_EXEC_SRA_EN
    localparam logic [1:0] SH_ARITH = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [4:0]       cnt;
    logic [1:0]       mode_r;

    logic [WIDTH-1:0] sum, diff, comb_result;
    logic             ovf_add, ovf_sub, slt;
    logic             comb_ovf, comb_ill, is_shift;
    logic [1:0]       comb_mode;
    logic             accept;
    logic             start_shift;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign start_shift = is_shift && (b[4:0] != 5'd0);

    // Single-cycle operation results, flags and shift classification of the request
    always_comb begin
        sum         = a + b;
        diff        = a - b;
        ovf_add     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_sub     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        slt         = diff[WIDTH-1] ^ ovf_sub;
        comb_result = '0;
        comb_ovf    = 1'b0;
        comb_ill    = 1'b0;
        is_shift    = 1'b0;
        comb_mode   = SH_LEFT;
        case (control)
            OP_AND:  comb_result = a & b;
            OP_OR:   comb_result = a | b;
            OP_ADD: begin
                comb_result = sum;
                comb_ovf    = ovf_add;
            end
            OP_PASS: comb_result = b;
            OP_SUB: begin
                comb_result = diff;
                comb_ovf    = ovf_sub;
            end
            OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, slt};
            // Zero-count shifts complete immediately with a unchanged
            OP_SLL: begin
                comb_result = a;
                is_shift    = 1'b1;
                comb_mode   = SH_LEFT;
            end
            OP_SRL: begin
                comb_result = a;
                is_shift    = 1'b1;
                comb_mode   = SH_RIGHT;
            end
`ifdef ALU_EXEC_SRA_EN
            OP_SRA: begin
                comb_result = a;
                is_shift    = 1'b1;
                comb_mode   = SH_ARITH;
            end
`endif
            OP_NOR:  comb_result = ~(a | b);
            default: comb_ill = 1'b1;
        endcase
    end

    // One-bit step of the shift register in the captured direction
    always_comb begin
        shreg_next = shreg;
        case (mode_r)
            SH_LEFT:  shreg_next = {shreg[WIDTH-2:0], 1'b0};
`ifdef ALU_EXEC_SRA_EN
            SH_ARITH: shreg_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
`endif
            default:  shreg_next = {1'b0, shreg[WIDTH-1:1]};
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == 5'd1) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, step shifts, publish result only when final
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            cnt      <= '0;
            mode_r   <= SH_LEFT;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start_shift) begin
                            shreg  <= a;
                            cnt    <= b[4:0];
                            mode_r <= comb_mode;
                        end else begin
                            result   <= comb_result;
                            zero     <= (comb_result == '0);
                            overflow <= comb_ovf;
                            illegal  <= comb_ill;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result   <= shreg_next;
                        zero     <= (shreg_next == '0);
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_iter.sv
// tb/tb_alu_exec_iter.sv - directed self-checking bench for alu_exec_iter
module tb_alu_exec_iter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  control;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int passed = 0;
    int total  = 0;

    alu_exec_iter #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request at post-edge time, wait for the result, check it, consume it.
    // ewait = clock edges after the accept edge before out_valid rises.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eres, input logic ez,
                          input logic eo, input logic ei, input int ewait);
        int   w;
        logic ir_bad;
        chk({tag, ".in_ready_before"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        control  = c;
        a        = av;
        b        = bv;
        @(posedge clock); #1;
        in_valid = 1'b0;
        a        = 32'h5A5A_5A5A;
        b        = 32'hA5A5_A5A5;
        w        = 0;
        ir_bad   = in_ready;
        while (!out_valid && w < 64) begin
            @(posedge clock); #1;
            if (in_ready) ir_bad = 1'b1;
            w++;
        end
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".wait"}, w, ewait);
        chk({tag, ".in_ready_low"}, {31'b0, ir_bad}, 32'd0);
        chk({tag, ".result"}, result, eres);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
        chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
        chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ei});
        @(posedge clock); #1;
        chk({tag, ".consumed"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        control   = 4'b0000;
        a         = 32'h0;
        b         = 32'h0;
        #3;
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset.result", result, 32'h0);
        chk("reset.flags", {29'b0, zero, overflow, illegal}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        run_op("slt_ovf", 4'b0111, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 0);
        run_op("slt_swap", 4'b0111, 32'h1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 0);
        run_op("or", 4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0);
        run_op("pass", 4'b0011, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 0);
        run_op("sll31", 4'b1001, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 31);
        run_op("srl4", 4'b1010, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 4);
        run_op("sll0", 4'b1001, 32'hABCD_1234, 32'd0, 32'hABCD_1234, 1'b0, 1'b0, 1'b0, 0);
        run_op("srl32", 4'b1010, 32'h8765_4321, 32'h20, 32'h8765_4321, 1'b0, 1'b0, 1'b0, 0);
        run_op("srl_out", 4'b1010, 32'h0000_0001, 32'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1);
        run_op("undef0100", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1, 0);
`ifdef ALU_EXEC_SRA_EN
        run_op("sra4", 4'b1011, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, 1'b0, 1'b0, 4);
`else
        run_op("undef1011", 4'b1011, 32'hF000_0000, 32'd4, 32'h0, 1'b1, 1'b0, 1'b1, 0);
`endif

        // Backpressure: NOR result held through a 10-cycle stall, stray requests ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        control   = 4'b1100;
        a         = 32'h0;
        b         = 32'h0;
        @(posedge clock); #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            control  = 4'b0010;
            a        = 32'h1;
            b        = 32'h1;
            chk("stall.out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall.result", result, 32'hFFFF_FFFF);
            chk("stall.zero_ready", {30'b0, zero, in_ready}, 32'd0);
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall.still_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clock); #1;
        chk("stall.consumed", {30'b0, out_valid, in_ready}, 32'b01);
        chk("stall.result_kept", result, 32'hFFFF_FFFF);

        // Reset mid-shift discards the pending operation
        in_valid = 1'b1;
        control  = 4'b1001;
        a        = 32'h1;
        b        = 32'd20;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("midshift.busy", {30'b0, out_valid, in_ready}, 32'b00);
        reset_n = 1'b0;
        #1;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.result", result, 32'h0);
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'h5, 1'b0, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
